// File: rtl/lvds_fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the LVDS FIFO write arbiter.
package lvds_fifo_wr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int ARB_MAX_CH = 8;

  // Ceiling log2, never below 1 so a pointer always has at least one bit.
  function automatic int arb_clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/lvds_fifo_wr_arbiter_rr_grant_sel.sv
// Combinational round-robin winner select: rotate the request vector by the
// pointer, priority-encode the lowest set bit, then rotate the index back.
module rr_grant_sel
  import lvds_fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = arb_clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] onehot,
  output logic [PTR_W-1:0]  idx
);

  localparam logic [PTR_W:0] NCH = (PTR_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] rot;
  logic [PTR_W-1:0]  offset;
  logic [PTR_W:0]    sum;

  // Low half of the double-width copy shifted by ptr is req rotated right.
  assign rot = NUM_CH'({req, req} >> ptr);

  always_comb begin
    offset = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) offset = PTR_W'(i);
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, offset};
  assign idx = (sum >= NCH) ? PTR_W'(sum - NCH) : sum[PTR_W-1:0];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
      assign onehot[gi] = (|req) && (idx == PTR_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/lvds_fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one FIFO write port.
// Optional LVDS_ARB_PRIO_CH0_EN: channel 0 always wins arbitration in IDLE.
module lvds_fifo_wr_arbiter
  import lvds_fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CH-1:0]            i_req,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_CH-1:0]            i_last,
  output logic [NUM_CH-1:0]            o_ack,
  output logic [NUM_CH-1:0]            o_grant,
  output logic                         o_busy,
  output logic                         o_fifo_wr,
  output logic [DATA_WIDTH-1:0]        o_fifo_data,
  input  logic                         i_fifo_full
);

  localparam int PTR_W = arb_clog2(NUM_CH);

  generate
    if (NUM_CH < 2 || NUM_CH > ARB_MAX_CH) begin : g_bad_num_ch
      $error("lvds_fifo_wr_arbiter: NUM_CH out of range");
    end
  endgenerate

  arb_state_t              state_reg, state_next;
  logic [NUM_CH-1:0]       grant_reg, grant_next;
  logic [PTR_W-1:0]        gidx_reg, gidx_next;
  logic [PTR_W-1:0]        ptr_reg, ptr_next;
  logic [NUM_CH-1:0]       sel_onehot, win_onehot;
  logic [PTR_W-1:0]        sel_idx, win_idx;
  logic [NUM_CH-1:0]       ack;
  logic                    release_pkt;
  logic [DATA_WIDTH-1:0]   masked_data [NUM_CH];
  logic [DATA_WIDTH-1:0]   fifo_data_mux;

  rr_grant_sel #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_sel (
    .req    (i_req),
    .ptr    (ptr_reg),
    .onehot (sel_onehot),
    .idx    (sel_idx)
  );

`ifdef LVDS_ARB_PRIO_CH0_EN
  assign win_onehot = i_req[0] ? NUM_CH'(1) : sel_onehot;
  assign win_idx    = i_req[0] ? '0 : sel_idx;
`else
  assign win_onehot = sel_onehot;
  assign win_idx    = sel_idx;
`endif

  // grant_reg is all-zero in IDLE, so nothing can be acked there.
  assign ack         = grant_reg & i_req & {NUM_CH{~i_fifo_full}};
  assign release_pkt = |(ack & i_last);

  assign o_ack     = ack;
  assign o_fifo_wr = |ack;
  assign o_grant   = grant_reg;
  assign o_busy    = (state_reg == ARB_LOCK);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_data_mask
      assign masked_data[gi] = grant_reg[gi] ? i_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    fifo_data_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fifo_data_mux = fifo_data_mux | masked_data[i];
    end
  end

  assign o_fifo_data = fifo_data_mux;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    gidx_next  = gidx_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (|i_req) begin
          grant_next = win_onehot;
          gidx_next  = win_idx;
          state_next = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        if (release_pkt) begin
          grant_next = '0;
          ptr_next   = (gidx_reg == PTR_W'(NUM_CH - 1)) ? '0 : gidx_reg + PTR_W'(1);
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= ARB_IDLE;
      grant_reg <= '0;
      gidx_reg  <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      gidx_reg  <= gidx_next;
      ptr_reg   <= ptr_next;
    end
  end

endmodule

// File: tb/tb_lvds_fifo_wr_arbiter.sv
// Self-checking bench for lvds_fifo_wr_arbiter: directed scenarios followed by
// randomized packet traffic, all compared against a behavioural model.
module tb_lvds_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int QMAX  = 256;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [N-1:0]  i_req, i_last, o_ack, o_grant;
  logic [N*DW-1:0] i_data;
  logic          i_fifo_full, o_busy, o_fifo_wr;
  logic [DW-1:0] o_fifo_data;

  always #5 i_clk = ~i_clk;

  lvds_fifo_wr_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req),
    .i_data      (i_data),
    .i_last      (i_last),
    .o_ack       (o_ack),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_fifo_wr   (o_fifo_wr),
    .o_fifo_data (o_fifo_data),
    .i_fifo_full (i_fifo_full)
  );

  int tests = 0;
  int fails = 0;

  // Requester word queues: bit DW is the last flag.
  logic [DW:0]   wq [N][QMAX];
  int            head [N];
  int            tail [N];
  int            gap [N];
  bit            drop [N];
  int            gap_max = 0;
  bit            pop_en = 1'b0;
  int            force_cnt = 0;

  logic [DW-1:0] fifo_q[$];
  int            grant_log[$];
  int            first_ack [N];
  int            last_ack [N];
  int            dut_wr_count = 0;

  // Reference model: current packet owner (-1 when idle) and search start.
  int            owner = -1;
  int            ptr = 0;
  int            cyc = 0;

  logic [N-1:0]  ob_ack, ob_grant;
  logic [N-1:0]  prev_grant = '0;
  logic          ob_wr, ob_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick_winner(input logic [N-1:0] r);
`ifdef LVDS_ARB_PRIO_CH0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int k = 0; k < N; k++) if (g[k]) return k;
    return -1;
  endfunction

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (head[k] < tail[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input int k, input logic [DW-1:0] d, input logic l);
    wq[k][tail[k]] = {l, d};
    tail[k]++;
  endtask

  task automatic clear_marks();
    for (int k = 0; k < N; k++) begin
      first_ack[k] = -1;
      last_ack[k]  = -1;
    end
    grant_log.delete();
    fifo_q.delete();
  endtask

  task automatic run_cycle(input bit do_rst);
    logic [N-1:0]  e_ack, e_grant;
    logic [DW-1:0] e_data;
    @(negedge i_clk);
    i_rst_n = ~do_rst;
    for (int k = 0; k < N; k++) begin
      i_req[k] = (head[k] < tail[k]) && (gap[k] == 0) && !drop[k];
      if (head[k] < tail[k]) begin
        i_data[k*DW +: DW] = wq[k][head[k]][DW-1:0];
        i_last[k]          = wq[k][head[k]][DW];
      end else begin
        i_data[k*DW +: DW] = DW'($urandom);
        i_last[k]          = 1'b0;
      end
    end
    i_fifo_full = (force_cnt > 0) || (fifo_q.size() >= DEPTH);
    #1;
    e_grant = '0;
    e_ack   = '0;
    e_data  = '0;
    if (owner >= 0) begin
      e_grant[owner] = 1'b1;
      e_ack[owner]   = i_req[owner] && !i_fifo_full;
      e_data         = i_data[owner*DW +: DW];
    end
    if (!do_rst) begin
      chk("grant", 32'(o_grant), 32'(e_grant));
      chk("busy", 32'(o_busy), 32'(owner >= 0));
      chk("ack", 32'(o_ack), 32'(e_ack));
      chk("fifo_wr", 32'(o_fifo_wr), 32'(|e_ack));
      chk("fifo_data", 32'(o_fifo_data), 32'(e_data));
    end
    ob_ack   = o_ack;
    ob_grant = o_grant;
    ob_wr    = o_fifo_wr;
    ob_busy  = o_busy;

    for (int k = 0; k < N; k++) if (gap[k] > 0) gap[k]--;
    if (!do_rst) begin
      if (o_fifo_wr) begin
        fifo_q.push_back(o_fifo_data);
        dut_wr_count++;
      end
      for (int k = 0; k < N; k++) begin
        if (o_ack[k]) begin
          if (first_ack[k] < 0) first_ack[k] = cyc;
          last_ack[k] = cyc;
          if (head[k] < tail[k]) head[k]++;
          gap[k] = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        end
      end
      if (o_grant != '0 && prev_grant == '0) grant_log.push_back(onehot_idx(o_grant));
    end
    prev_grant = o_grant;

    if (do_rst) begin
      owner = -1;
      ptr   = 0;
      for (int k = 0; k < N; k++) begin
        head[k] = tail[k];
        gap[k]  = 0;
      end
    end else if (owner < 0) begin
      if (|i_req) owner = pick_winner(i_req);
    end else if (e_ack[owner] && i_last[owner]) begin
      ptr   = (owner + 1) % N;
      owner = -1;
    end

    if (pop_en && fifo_q.size() > 0 && $urandom_range(0, 2) == 0) void'(fifo_q.pop_front());
    if (force_cnt > 0) force_cnt--;
    cyc++;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((pending() || owner >= 0) && n < budget) begin
      run_cycle(1'b0);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int start, exp_first, start_wr, total, len, seq;
    i_rst_n = 1'b0;
    i_req = '0;
    i_last = '0;
    i_data = '0;
    i_fifo_full = 1'b0;
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
      gap[k]  = 0;
      drop[k] = 1'b0;
    end
    clear_marks();

    // Reset state
    run_cycle(1'b1);
    run_cycle(1'b1);
    run_cycle(1'b0);
    chk("rst_grant", 32'(ob_grant), 32'd0);
    chk("rst_busy", 32'(ob_busy), 32'd0);
    chk("rst_wr", 32'(ob_wr), 32'd0);

    // Contention: all four channels, two words each
    clear_marks();
    start = cyc;
    for (int k = 0; k < N; k++) begin
      push(k, 8'(k * 16), 1'b0);
      push(k, 8'(k * 16 + 1), 1'b1);
    end
    run_until_idle("cont_budget", 40);
    chk("cont_cycles", 32'(last_ack[3] - start), 32'd11);
    for (int i = 0; i < N; i++)
      chk("cont_grant_order", 32'(grant_log.size() > i ? grant_log[i] : -1), 32'(i));
    for (int i = 0; i < 8; i++)
      chk("cont_fifo", 32'(fifo_q.size() > i ? int'(fifo_q[i]) : -1), 32'((i / 2) * 16 + (i % 2)));

    // Backpressure: ch2, full for 4 cycles after the first word
    clear_marks();
    push(2, 8'h2a, 1'b0);
    push(2, 8'h2b, 1'b0);
    push(2, 8'h2c, 1'b1);
    run_cycle(1'b0);
    run_cycle(1'b0);
    force_cnt = 4;
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0);
      chk("bp_no_ack", 32'(ob_ack), 32'd0);
      chk("bp_grant", 32'(ob_grant), 32'b0100);
    end
    run_until_idle("bp_budget", 20);
    chk("bp_count", 32'(fifo_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("bp_fifo", 32'(fifo_q.size() > i ? int'(fifo_q[i]) : -1), 32'(8'h2a + i));

    // Non-interleaving: ch3 requests while ch1 is mid-packet
    clear_marks();
    push(1, 8'h1a, 1'b0);
    push(1, 8'h1b, 1'b0);
    push(1, 8'h1c, 1'b1);
    run_cycle(1'b0);
    run_cycle(1'b0);
    push(3, 8'h3c, 1'b1);
    run_until_idle("ni_budget", 20);
    chk("ni_ch3_after_release", 32'(first_ack[3]), 32'(last_ack[1] + 2));
    chk("ni_order", 32'(fifo_q.size() == 4 ? int'(fifo_q[3]) : -1), 32'h3c);

    // Priority: move the pointer to 2, then ch0 and ch2 request together
    clear_marks();
    push(1, 8'h55, 1'b1);
    run_until_idle("prio_setup_budget", 20);
    grant_log.delete();
    push(0, 8'h0a, 1'b1);
    push(2, 8'h2a, 1'b1);
    run_until_idle("prio_budget", 20);
`ifdef LVDS_ARB_PRIO_CH0_EN
    exp_first = 0;
`else
    exp_first = 2;
`endif
    chk("prio_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'(exp_first));
    chk("prio_second_grant", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'(2 - exp_first));

    // Reset during ch1's second word
    clear_marks();
    push(1, 8'h61, 1'b0);
    push(1, 8'h62, 1'b0);
    push(1, 8'h63, 1'b1);
    run_cycle(1'b0);
    run_cycle(1'b0);
    run_cycle(1'b1);
    run_cycle(1'b0);
    chk("rstmid_grant", 32'(ob_grant), 32'd0);
    chk("rstmid_ack", 32'(ob_ack), 32'd0);
    chk("rstmid_busy", 32'(ob_busy), 32'd0);
    chk("rstmid_wr", 32'(ob_wr), 32'd0);
    grant_log.delete();
    push(0, 8'h70, 1'b1);
    push(1, 8'h71, 1'b1);
    run_until_idle("rstmid_budget", 20);
    chk("rstmid_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);

    // Single-word packets on ch3: one write every two cycles
    clear_marks();
    start_wr = dut_wr_count;
    for (int i = 0; i < 6; i++) push(3, 8'(8'h80 + i), 1'b1);
    for (int i = 0; i < 12; i++) run_cycle(1'b0);
    chk("single_writes", 32'(dut_wr_count - start_wr), 32'd6);

    // Dropped request mid-packet holds the lock without writing
    clear_marks();
    push(3, 8'h3a, 1'b0);
    push(3, 8'h3b, 1'b1);
    run_cycle(1'b0);
    run_cycle(1'b0);
    drop[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0);
      chk("drop_grant", 32'(ob_grant), 32'b1000);
      chk("drop_no_wr", 32'(ob_wr), 32'd0);
    end
    drop[3] = 1'b0;
    run_until_idle("drop_budget", 20);
    chk("drop_fifo", 32'(fifo_q.size() == 2 ? int'(fifo_q[1]) : -1), 32'h3b);

    // Randomized traffic with gaps, consumer pops and forced-full bursts
    clear_marks();
    pop_en  = 1'b1;
    gap_max = 2;
    total   = 0;
    seq     = 0;
    for (int k = 0; k < N; k++) begin
      for (int p = 0; p < 10; p++) begin
        len = int'($urandom_range(1, 4));
        for (int w = 0; w < len; w++) begin
          push(k, 8'((k << 6) | (seq & 63)), w == len - 1);
          seq++;
          total++;
        end
      end
    end
    start_wr = dut_wr_count;
    for (int n = 0; n < 3000 && (pending() || owner >= 0); n++) begin
      if (force_cnt == 0 && $urandom_range(0, 15) == 0) force_cnt = int'($urandom_range(1, 3));
      run_cycle(1'b0);
    end
    chk("rand_drained", 32'(pending() || owner >= 0), 32'd0);
    chk("rand_words", 32'(dut_wr_count - start_wr), 32'(total));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lvds_fifo_wr_arbiter.md
# lvds_fifo_wr_arbiter

Round-robin, packet-locked write arbiter that shares one synchronous FIFO write port between `NUM_CH` requesters, e.g. payload, ack/nack and credit frame sources in the LVDS transmit path. A requester keeps its grant until it writes the word flagged `last`, so packets never interleave in the FIFO. The FIFO full flag provides backpressure.

## Interface
- `NUM_CH`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: word width; must equal the FIFO `DATA_WIDTH`.
- `i_clk` input 1: clock; all logic on rising edge.
- `i_rst_n` input 1: reset, synchronous, active-low.
- `i_req` input NUM_CH: channel k has a word valid on its data slice.
- `i_data` input NUM_CH*DATA_WIDTH: channel k data at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `i_last` input NUM_CH: current word of channel k ends its packet.
- `o_ack` output NUM_CH: combinational; word of channel k is accepted this cycle.
- `o_grant` output NUM_CH: registered one-hot grant; all zero when idle.
- `o_busy` output 1: registered; high while in LOCK.
- `o_fifo_wr` output 1: combinational FIFO write strobe, equal to the OR of `o_ack`.
- `o_fifo_data` output DATA_WIDTH: combinational; granted channel's data, zero when no grant.
- `i_fifo_full` input 1: FIFO full flag.

## Operation
- **FSM states:** IDLE, LOCK.
- **IDLE:**
  - If any `i_req` is set, select the winner by searching upward from `r_ptr`, modulo NUM_CH.
  - Register the one-hot `o_grant` and go to LOCK.
  - No word is accepted while in IDLE.
- **LOCK:**
  - `o_ack[g] = o_grant[g] & i_req[g] & ~i_fifo_full`.
  - A transfer with `i_last[g]` set releases the grant: `o_grant` goes to 0, `r_ptr` becomes (g+1) mod NUM_CH, and the next state is IDLE.
- **Requester rules:**
  - A requester holds `i_req`, `i_data` and `i_last` stable until acked.
  - Dropping `i_req` mid-packet stalls the lock. The grant is kept and no timeout exists.
  - Requests from non-granted channels are ignored during LOCK.
- **Single-word packet:** `i_last` on the first word releases after one transfer.
- **FIFO full:** no ack and no write. The grant is held and the word is retried each cycle until full deasserts.
- **Reset:**
  - Reset values: `o_grant`=0, `o_busy`=0, `o_ack`=0, `o_fifo_wr`=0, `o_fifo_data`=0, `r_ptr`=0, state IDLE.
  - Reset mid-packet abandons the lock. Words already written stay in the FIFO; purging them is the consumer's responsibility.

## Timing
- **Arbitration latency:**
  - Request seen in IDLE at cycle t: `o_grant` and `o_busy` are high from t+1.
  - The first ack can occur at t+1, and the word is stored at the end of t+1.
- **Packet length:** an unstalled L-word packet occupies L+1 cycles, 1 arbitration plus L transfers.
- **Back-to-back packets:** exactly one idle cycle between them.
- **Full timing:** `i_fifo_full` is used the same cycle; no registered lookahead.

## Configuration
- `LVDS_ARB_PRIO_CH0_EN` defined:
  - In IDLE, channel 0 wins whenever `i_req[0]` is set, regardless of `r_ptr`. Acks and nacks therefore bypass queued payload after the current packet.
  - Otherwise the round-robin search is unchanged.
  - `r_ptr` still updates to (g+1) mod NUM_CH on every release.
- Not defined: pure round-robin over all channels.

## Structure
- **Shared package:**
  - FSM state encoding `ARB_IDLE`=1'b0, `ARB_LOCK`=1'b1.
  - Constant `ARB_MAX_CH`=8 (checked against `NUM_CH`).
  - Helper for the ceiling log2 used to size `r_ptr`.
- **Sub-module `rr_grant_sel`:** purely combinational.
  - Inputs: request vector and `r_ptr`.
  - Outputs: one-hot winner and its binary index, implemented as a double-width rotate-and-priority-encode.
  - The FSM, pointer register and data mux stay in the top module.

## Test plan
All scenarios use NUM_CH=4, DATA_WIDTH=8, and an attached 8-deep FIFO.

- **Contention:** after reset, `i_req`=4'b1111 with each channel sending 2 words (ch k data 8'hk0 and 8'hk1, last on the second).
  - Grant order ch0, ch1, ch2, ch3.
  - FIFO holds 00,01,10,11,20,21,30,31.
  - 12 cycles total.
- **Backpressure:** ch2 sends a 3-word packet while `i_fifo_full` is forced high for 4 cycles after the first word.
  - No acks during the full window and `o_grant` stays 4'b0100.
  - Words resume in order with no loss or duplication.
- **Non-interleaving:** ch1 locked mid-packet while ch3 asserts `i_req`.
  - ch3 gets no ack until ch1's last word.
  - ch3 is granted one cycle after ch1 releases.
- **Priority macro:** with `LVDS_ARB_PRIO_CH0_EN`, `r_ptr`=2 and `i_req`=4'b0101.
  - ch0 granted first.
  - Without the macro, ch2 is granted first.
- **Reset mid-packet:** `i_rst_n` low during ch1's second word.
  - Next cycle all outputs are 0 and `r_ptr`=0.
  - After release, `i_req`=4'b0011 grants ch0.
- **Single-word packets and dropped request:** ch3 sends single-word packets continuously.
  - One write every 2 cycles.
  - Dropping `i_req[3]` while locked keeps `o_grant`=4'b1000 with no write.
